// File: rtl/pc_srio_pkg.sv
// pc_srio_pkg: shared constants, FSM encoding and FIFO word layout for pc_srio_pack
package pc_srio_pkg;
  localparam logic [15:0] HDR_MAGIC = 16'hA55A;
  typedef enum logic [1:0] {IDLE, DATA, HDR} state_t;
  typedef struct packed {
    logic        sof;
    logic        eof;
    logic [63:0] data;
  } fifo_word_t;
  function automatic logic [63:0] hdr_word(input logic [15:0] cnt, input logic [31:0] pc);
    return {HDR_MAGIC, cnt, pc};
  endfunction
endpackage

// File: rtl/pc_srio_fifo.sv
// pc_srio_fifo: first-word-fall-through FIFO of 66-bit {sof, eof, data} words
//  clk/rst_n        clock, async active-low reset
//  wr_en/din/full   write side; a write while full is accepted only if a read happens in the same cycle
//  rd_en/dout/empty read side; dout shows the head word whenever ~empty, 0 when empty
module pc_srio_fifo
  import pc_srio_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  fifo_word_t din,
  output logic       full,
  input  logic       rd_en,
  output fifo_word_t dout,
  output logic       empty
);
  localparam int DEPTH = 2 ** AW;
  fifo_word_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_rd, do_wr;
  assign empty = cnt == '0;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign do_rd = rd_en & ~empty;
  // a read frees the head slot this cycle, so a full FIFO can still take a write
  assign do_wr = wr_en & (~full | do_rd);
  assign dout  = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      wp  <= wp + AW'(do_wr);
      rp  <= rp + AW'(do_rd);
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
endmodule

// File: rtl/pc_srio_pack.sv
// pc_srio_pack: frames pulse-compressed I/Q samples into 64-bit SRIO words, one frame per PRI
//  clk_200M, rst_n                  clock, async active-low reset
//  PRI, cnt_srio                    frame strobe (rising edge opens a frame) and samples per frame
//  pc_valid, pc_I, pc_Q             input samples
//  srio_dout/sof/eof/valid, ready   FWFT output stream
//  pri_cnt                          PRI edges since reset
//  ovf_err, short_err               sticky drop / truncated-frame flags
module pc_srio_pack
  import pc_srio_pkg::*;
#(
  parameter int DW      = 16,
  parameter int CNT_W   = 16,
  parameter int FIFO_AW = 9
) (
  input  logic             clk_200M,
  input  logic             rst_n,
  input  logic             PRI,
  input  logic [CNT_W-1:0] cnt_srio,
  input  logic             pc_valid,
  input  logic [DW-1:0]    pc_I,
  input  logic [DW-1:0]    pc_Q,
  output logic [63:0]      srio_dout,
  output logic             srio_sof,
  output logic             srio_eof,
  output logic             srio_valid,
  input  logic             srio_ready,
  output logic [31:0]      pri_cnt,
  output logic             ovf_err,
  output logic             short_err
);
  state_t state, state_n;
  logic pri_d1, pri_edge, pending, last, half_ld, wr_en, cut, full, empty, rd;
  logic [CNT_W-1:0] cnt_q, cnt_n, scnt, scnt_n, scnt_p1;
  logic [2*DW-1:0] half;
  fifo_word_t wr_word, rd_word;
  assign pri_edge = PRI & ~pri_d1;
  assign pending  = scnt[0];
  assign scnt_p1  = scnt + CNT_W'(1);
  assign last     = scnt_p1 == cnt_q;
  assign rd       = srio_valid & srio_ready;
  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    scnt_n  = scnt;
    half_ld = 1'b0;
    wr_en   = 1'b0;
    wr_word = '0;
    cut     = 1'b0;
    if (pri_edge && state != HDR) begin
      cnt_n  = cnt_srio;
      scnt_n = '0;
      cut    = state == DATA;
      wr_en  = 1'b1;
      // a pending half word must go out first, so the new header slips to the HDR cycle
      if (state == DATA && pending) begin
        wr_word = '{sof: 1'b0, eof: 1'b1, data: {32'b0, half}};
        state_n = HDR;
      end else begin
        wr_word = '{sof: 1'b1, eof: cnt_srio == '0, data: hdr_word(cnt_srio[15:0], pri_cnt)};
        state_n = cnt_srio != '0 ? DATA : IDLE;
      end
    end else if (state == HDR) begin
      // pri_cnt already counted this frame's edge, so its header index is one less
      wr_en   = 1'b1;
      wr_word = '{sof: 1'b1, eof: cnt_q == '0, data: hdr_word(cnt_q[15:0], pri_cnt - 32'd1)};
      state_n = cnt_q != '0 ? DATA : IDLE;
      half_ld = pc_valid && cnt_q != '0;
      scnt_n  = half_ld ? CNT_W'(1) : '0;
    end else if (state == DATA) begin
      // a one-sample frame whose sample arrived during HDR still owes its word
      if (pending && scnt == cnt_q) begin
        wr_en   = 1'b1;
        wr_word = '{sof: 1'b0, eof: 1'b1, data: {32'b0, half}};
        state_n = IDLE;
      end else if (pc_valid) begin
        scnt_n  = scnt_p1;
        half_ld = ~pending;
        wr_en   = pending | last;
        wr_word = '{sof: 1'b0, eof: last, data: pending ? {pc_Q, pc_I, half} : {32'b0, pc_Q, pc_I}};
        state_n = last ? IDLE : DATA;
      end
    end
  end
  always_ff @(posedge clk_200M or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      pri_d1    <= 1'b0;
      pri_cnt   <= '0;
      cnt_q     <= '0;
      scnt      <= '0;
      half      <= '0;
      ovf_err   <= 1'b0;
      short_err <= 1'b0;
    end else begin
      state     <= state_n;
      pri_d1    <= PRI;
      pri_cnt   <= pri_cnt + 32'(pri_edge);
      cnt_q     <= cnt_n;
      scnt      <= scnt_n;
      half      <= half_ld ? {pc_Q, pc_I} : half;
      ovf_err   <= ovf_err | (wr_en & full & ~rd);
      short_err <= short_err | cut;
    end
  pc_srio_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk_200M),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .din   (wr_word),
    .full  (full),
    .rd_en (srio_ready),
    .dout  (rd_word),
    .empty (empty)
  );
  assign srio_valid = ~empty;
  assign srio_dout  = rd_word.data;
  assign srio_sof   = rd_word.sof;
  assign srio_eof   = rd_word.eof;
endmodule
